// File: rtl/conv_out_addr_gen.sv
// Output-memory address/strobe generator for a convolution layer: counts MAC
// cycles per pixel, then writes one result per pixel, per channel.
module conv_out_addr_gen #(
  parameter int IMG_W          = 8,
  parameter int IMG_H          = 8,
  parameter int CHANNELS       = 3,
  parameter int MACS_PER_PIXEL = 25,
  parameter int PIX_W  = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  parameter int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int ADDR_W = (IMG_W * IMG_H * CHANNELS > 1) ? $clog2(IMG_W * IMG_H * CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  pix_addr,
  output logic [CH_W-1:0]   chan,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CYC_W = (MACS_PER_PIXEL > 1) ? $clog2(MACS_PER_PIXEL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(MACS_PER_PIXEL - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);

  logic [1:0]        r_state;
  logic [CYC_W-1:0]  r_cyc;
  logic [PIX_W-1:0]  r_pix;
  logic [CH_W-1:0]   r_chan;
  logic [ADDR_W-1:0] r_addr;

  logic w_run;
  logic w_wr;
  logic w_pix_end;
  logic w_last;

  assign w_run     = (r_state == S_RUN);
  assign w_wr      = w_run && enable && (r_cyc == CYC_LAST);
  assign w_pix_end = (r_pix == PIX_LAST);
  assign w_last    = w_wr && w_pix_end && (r_chan == CH_LAST);

  // r_addr tracks chan*NPIX + pix incrementally: the flat address advances by
  // exactly one per write, including across the channel boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_pix   <= '0;
      r_chan  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cyc   <= '0;
            r_pix   <= '0;
            r_chan  <= '0;
            r_addr  <= '0;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (r_cyc == CYC_LAST) begin
              r_cyc <= '0;
              // Final write: leave pix/chan/addr on the last pixel of the pass.
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_pix_end) begin
                  r_pix  <= '0;
                  r_chan <= r_chan + CH_W'(1);
                end else begin
                  r_pix <= r_pix + PIX_W'(1);
                end
              end
            end else begin
              r_cyc <= r_cyc + CYC_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en       = w_wr;
  assign wr_addr     = r_addr;
  assign pix_addr    = r_pix;
  assign chan        = r_chan;
  assign last        = w_last;
  assign busy        = w_run;
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_out_addr_gen.sv
// Bench for conv_out_addr_gen: three parameterisations, a pass-level reference
// model, an address scoreboard, a cycle table and hand-written corner sequences.
module tb_conv_out_addr_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic st_a, en_a, st_b, en_b, st_c, en_c;

  logic       we_a, last_a, busy_a, done_a;
  logic [7:0] addr_a;
  logic [5:0] pix_a;
  logic [1:0] ch_a, dbg_a;

  logic       we_b, last_b, busy_b, done_b;
  logic [4:0] addr_b;
  logic [3:0] pix_b;
  logic [0:0] ch_b;
  logic [1:0] dbg_b;

  logic       we_c, last_c, busy_c, done_c;
  logic [0:0] addr_c, pix_c, ch_c;
  logic [1:0] dbg_c;

  int n_checks = 0;
  int n_pass   = 0;
  int writes_a = 0;
  logic [7:0] exp_q[$];
  int m_mode[3];
  int m_n[3];

  always #5 clk = ~clk;

  conv_out_addr_gen dut_a (
    .clk(clk), .reset_n(rst_n), .start(st_a), .enable(en_a),
    .wr_en(we_a), .wr_addr(addr_a), .pix_addr(pix_a), .chan(ch_a),
    .last(last_a), .busy(busy_a), .done(done_a), .o_dbg_state(dbg_a)
  );

  conv_out_addr_gen #(.IMG_W(3), .IMG_H(3), .CHANNELS(2), .MACS_PER_PIXEL(1)) dut_b (
    .clk(clk), .reset_n(rst_n), .start(st_b), .enable(en_b),
    .wr_en(we_b), .wr_addr(addr_b), .pix_addr(pix_b), .chan(ch_b),
    .last(last_b), .busy(busy_b), .done(done_b), .o_dbg_state(dbg_b)
  );

  conv_out_addr_gen #(.IMG_W(1), .IMG_H(1), .CHANNELS(1), .MACS_PER_PIXEL(1)) dut_c (
    .clk(clk), .reset_n(rst_n), .start(st_c), .enable(en_c),
    .wr_en(we_c), .wr_addr(addr_c), .pix_addr(pix_c), .chan(ch_c),
    .last(last_c), .busy(busy_c), .done(done_c), .o_dbg_state(dbg_c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [39:0] pack(input logic we, input logic lst, input logic bsy,
                                       input logic dn, input int ch, input int pix, input int adr);
    return {we, lst, bsy, dn, ch[11:0], pix[11:0], adr[11:0]};
  endfunction

  // Pass-level model: a pass is TOTAL writes, one per MACS enabled RUN cycles;
  // n counts enabled RUN cycles, so write k = n/MACS is pixel k%NPIX of channel k/NPIX.
  task automatic model_step(input string name, input int id, input int macs, input int npix,
                            input int total, input logic rst, input logic st, input logic en,
                            input logic [39:0] act);
    int k, ph, p;
    logic we, lst;
    if (!rst) m_mode[id] = 0;
    k  = m_n[id] / macs;
    ph = m_n[id] % macs;
    p  = (m_mode[id] == 1) ? k : (m_mode[id] == 2) ? total - 1 : 0;
    we  = (m_mode[id] == 1) && en && (ph == macs - 1);
    lst = we && (k == total - 1);
    check(name, act, pack(we, lst, m_mode[id] == 1, m_mode[id] == 2, p / npix, p % npix, p));
    if (rst) begin
      if (m_mode[id] == 1) begin
        if (en) begin
          m_n[id]++;
          if (lst) m_mode[id] = 2;
        end
      end else if (st) begin
        m_mode[id] = 1;
        m_n[id]    = 0;
      end
    end
  endtask

  always @(negedge clk)
    model_step("model_a", 0, 25, 64, 192, rst_n, st_a, en_a,
               pack(we_a, last_a, busy_a, done_a, int'(ch_a), int'(pix_a), int'(addr_a)));
  always @(negedge clk)
    model_step("model_b", 1, 1, 9, 18, rst_n, st_b, en_b,
               pack(we_b, last_b, busy_b, done_b, int'(ch_b), int'(pix_b), int'(addr_b)));
  always @(negedge clk)
    model_step("model_c", 2, 1, 1, 1, rst_n, st_c, en_c,
               pack(we_c, last_c, busy_c, done_c, int'(ch_c), int'(pix_c), int'(addr_c)));

  // Address scoreboard for the default instance.
  always @(negedge clk) begin : sb_a
    int a;
    if (rst_n && we_a) begin
      writes_a++;
      if (exp_q.size() == 0) begin
        check("sb_extra_write", 1, 0);
      end else begin
        a = int'(exp_q.pop_front());
        check("sb_write", pack(1'b1, last_a, busy_a, done_a, int'(ch_a), int'(pix_a), int'(addr_a)),
              pack(1'b1, a == 191, 1'b1, 1'b0, a / 64, a % 64, a));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: enable high; 1: 7-cycle stall before write 5; 2: random enable;
  // 3: enable high with random start pulses during RUN.
  task automatic run_pass_a(input int mode, output int busy_cyc, output int stalls, output int nwr);
    int guard, w0, stall_left;
    logic stalled, released, was_done;
    guard = 0; stall_left = 0; stalled = 1'b0; released = 1'b0;
    busy_cyc = 0; stalls = 0;
    for (int i = 0; i < 192; i++) exp_q.push_back(8'(i));
    w0 = writes_a;
    was_done = done_a;
    st_a = 1'b1; en_a = 1'b1;
    tick();
    st_a = 1'b0;
    check("busy_rise", busy_a, 1);
    if (was_done) check("done_drop", {done_a, busy_a}, 2'b01);
    while (!done_a && guard < 12000) begin
      if (mode == 1 && !stalled && we_a && addr_a == 8'd5) begin
        stall_left = 7;
        stalled    = 1'b1;
      end
      if (mode == 1) begin
        if (stall_left > 0) begin
          en_a = 1'b0;
          stall_left--;
          #1 check("stall_hold", we_a, 0);
        end else if (stalled && !released) begin
          en_a = 1'b1;
          released = 1'b1;
          #1 check("stall_release", {we_a, addr_a}, {1'b1, 8'd5});
        end else begin
          en_a = 1'b1;
        end
      end else if (mode == 2) begin
        en_a = ($urandom_range(0, 3) != 0);
      end else begin
        en_a = 1'b1;
        if (mode == 3) st_a = logic'($urandom_range(0, 1));
      end
      if (busy_a) begin
        busy_cyc++;
        if (!en_a) stalls++;
      end
      tick();
      guard++;
    end
    st_a = 1'b0;
    en_a = 1'b1;
    check("pass_timeout", guard < 12000, 1);
    nwr = writes_a - w0;
    check("sb_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic st;
    logic en;
    logic we;
    logic lst;
    logic bsy;
    logic dn;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int bc, sc, nw, guard, wcnt, maxa;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    st_a = 1'b0; en_a = 1'b1;
    st_b = 1'b0; en_b = 1'b1;
    st_c = 1'b0; en_c = 1'b1;
    for (int i = 0; i < 3; i++) m_mode[i] = 0;
    for (int i = 0; i < 3; i++) m_n[i] = 0;
    tick(); tick();
    check("reset_a", {pack(we_a, last_a, busy_a, done_a, int'(ch_a), int'(pix_a), int'(addr_a)), dbg_a}, 42'd0);
    check("reset_b", pack(we_b, last_b, busy_b, done_b, int'(ch_b), int'(pix_b), int'(addr_b)), 40'd0);
    check("reset_c", pack(we_c, last_c, busy_c, done_c, int'(ch_c), int'(pix_c), int'(addr_c)), 40'd0);
    rst_n = 1'b1;
    tick();

    run_pass_a(0, bc, sc, nw);
    check("pass0_busy_cycles", bc, 4800);
    check("pass0_writes", nw, 192);

    run_pass_a(3, bc, sc, nw);
    check("restart_busy_cycles", bc, 4800);
    check("restart_writes", nw, 192);

    run_pass_a(1, bc, sc, nw);
    check("stall_busy_cycles", bc, 4807);
    check("stall_writes", nw, 192);

    run_pass_a(2, bc, sc, nw);
    check("rand_busy_cycles", bc, 4800 + sc);
    check("rand_writes", nw, 192);

    // Mid-pass reset at write 100, then a fresh pass from address 0.
    for (int i = 0; i < 192; i++) exp_q.push_back(8'(i));
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    guard = 0;
    while (!(we_a && addr_a == 8'd100) && guard < 6000) begin
      tick();
      guard++;
    end
    check("reach_write100", {we_a, addr_a}, {1'b1, 8'd100});
    rst_n = 1'b0;
    #1;
    check("async_reset", pack(we_a, last_a, busy_a, done_a, int'(ch_a), int'(pix_a), int'(addr_a)), 40'd0);
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_pass_a(0, bc, sc, nw);
    check("post_reset_busy_cycles", bc, 4800);
    check("post_reset_writes", nw, 192);

    // 3x3x2, one MAC per pixel: 18 back-to-back writes.
    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    bc = 0; wcnt = 0; maxa = 0; guard = 0;
    while (!done_b && guard < 100) begin
      if (busy_b) bc++;
      if (we_b) begin
        wcnt++;
        if (int'(addr_b) > maxa) maxa = int'(addr_b);
        if (addr_b == 5'd8) check("b_pix_end", {ch_b, pix_b}, {1'b0, 4'd8});
        if (addr_b == 5'd9) check("b_wrap", {ch_b, pix_b}, {1'b1, 4'd0});
      end
      tick();
      guard++;
    end
    check("b_busy_cycles", bc, 18);
    check("b_writes", wcnt, 18);
    check("b_max_addr", maxa, 17);
    check("b_final", {done_b, ch_b, pix_b, addr_b}, {1'b1, 1'b1, 4'd8, 5'd17});

    st_b = 1'b1;
    tick();
    st_b = 1'b0;
    guard = 0;
    while (!done_b && guard < 400) begin
      en_b = logic'($urandom_range(0, 1));
      tick();
      guard++;
    end
    en_b = 1'b1;
    check("b_rand_timeout", guard < 400, 1);

    // 1x1x1 cycle table.
    for (int i = 0; i < 8; i++) begin
      st_c = tbl[i].st;
      en_c = tbl[i].en;
      #1;
      check($sformatf("c_vec%0d", i), {we_c, last_c, busy_c, done_c, addr_c},
            {tbl[i].we, tbl[i].lst, tbl[i].bsy, tbl[i].dn, 1'b0});
      tick();
    end
    st_c = 1'b0;
    en_c = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_out_addr_gen.md
# conv_out_addr_gen

Parametrised address and write-enable generator for convolution-layer output memories. It counts a fixed number of accumulate cycles per output pixel, then issues one write strobe with the pixel/channel address. It walks an IMG_W × IMG_H output image once per channel, for CHANNELS channels. It sits between a convolution datapath (which produces one result every MACS_PER_PIXEL enabled cycles) and the layer's output RAM, and reports completion to the layer sequencer through a start/busy/done handshake.

## Interface
Parameters:
- IMG_W, 8, output image width in pixels (≥1)
- IMG_H, 8, output image height in pixels (≥1)
- CHANNELS, 3, output channels/feature maps (≥1)
- MACS_PER_PIXEL, 25, enabled cycles per output pixel (≥1)
- PIX_W, max(1,$clog2(IMG_W*IMG_H)), derived, pixel-index width
- CH_W, max(1,$clog2(CHANNELS)), derived, channel-index width
- ADDR_W, max(1,$clog2(IMG_W*IMG_H*CHANNELS)), derived, flat-address width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE or DONE
- enable  in  1  advance qualifier; low freezes all counters (stall)
- wr_en  out  1  write strobe to output RAM, one cycle per pixel
- wr_addr  out  ADDR_W  flat address = chan*IMG_W*IMG_H + pix_addr
- pix_addr  out  PIX_W  pixel index within current channel, row-major
- chan  out  CH_W  current channel index
- last  out  1  high with wr_en on the final write of the pass
- busy  out  1  high while in RUN
- done  out  1  high in DONE, held until start or reset

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: start=1 → RUN. All counters are cleared on entry to RUN.
- RUN: cycle counter `cyc` ranges 0..MACS_PER_PIXEL-1. It advances only when enable=1.
  - wr_en = RUN && enable && cyc==MACS_PER_PIXEL-1 (combinational from registered state).
  - On a write cycle: cyc→0, and pix_addr increments.
  - When pix_addr==IMG_W*IMG_H-1 on a write cycle: pix_addr→0 and chan increments.
  - last = wr_en && pix_addr==IMG_W*IMG_H-1 && chan==CHANNELS-1.
  - On a last cycle: next state is DONE. pix_addr and chan hold their final values.
- DONE: done=1. start=1 → RUN with counters cleared (new pass).
- start in RUN is ignored; it does not restart or extend the pass.
- wr_addr is the registered sum of the current chan/pix_addr. It must match the formula on every wr_en cycle.
- Counters never wrap past their limits. Non-power-of-two dimensions must not emit addresses ≥ IMG_W*IMG_H*CHANNELS.
- reset_n low at any time (including mid-pass) forces IDLE immediately. No write completes during reset.

## Timing
- Reset values: wr_en=0, wr_addr=0, pix_addr=0, chan=0, last=0, busy=0, done=0.
- start sampled high at edge N: busy=1 from N+1. The first wr_en occurs MACS_PER_PIXEL enabled cycles after entering RUN.
- A pass takes IMG_W*IMG_H*CHANNELS*MACS_PER_PIXEL enabled cycles in RUN. With defaults: 4800 cycles and 192 writes.
- done rises on the edge after the last write; busy falls on the same edge.
- A start in DONE clears done on the following edge and sets busy on that same edge.
- With enable=0 the state is frozen and wr_en=0. A write is delayed one cycle per stalled cycle, never dropped or duplicated.
- MACS_PER_PIXEL=1: wr_en is high on every enabled RUN cycle.

## Test plan
- Defaults, enable tied high, start pulse: 192 wr_en pulses spaced exactly 25 cycles apart. wr_addr runs 0..191 in order; chan steps 0→1→2 at addresses 64 and 128. last coincides only with address 191. done=1 exactly 4800 cycles after busy rises.
- IMG_W=3, IMG_H=3, CHANNELS=2, MACS_PER_PIXEL=1: 18 consecutive writes, addresses 0..17. pix_addr wraps at 8→0 when chan goes 0→1. No address ≥18 is ever issued.
- Stall: defaults, enable deasserted for 7 cycles with cyc=24 pending. wr_en stays 0 during the stall and fires on the first enabled cycle, with an unchanged address. Total RUN time is 4807 cycles.
- Mid-pass reset: assert reset_n=0 at write 100. All outputs become 0 asynchronously. A subsequent start begins again at wr_addr=0.
- start pulsed repeatedly during RUN: no effect on the address sequence or write count. A start in DONE launches a second identical 192-write pass, and done drops one cycle after start.
- CHANNELS=1, IMG_W=IMG_H=1, MACS_PER_PIXEL=1: the single write at address 0 has last=1. done is high on the next cycle.
